// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
//
// Output stage for the classifier. Each DATA_W-bit result arriving with its
// one-cycle valid strobe is queued in a small FIFO and then sent as a UART
// frame (start bit, 8 data bits LSB first, stop bit) on uart_txd. Everything
// runs in the PE clock domain.
//
// Parameters
//   BAUD_DIV    PE clock cycles per UART bit (2..65535)
//   FIFO_DEPTH  result FIFO entries (power of 2, >= 2)
//   DATA_W      result width (<= 8); the byte sent is the result zero-extended
//
// Ports
//   clk           PE clock, rising edge
//   rst           asynchronous active-high reset
//   en            transmit enable; only gates the start of a new frame
//   result_data   classification result, sampled while result_valid is high
//   result_valid  one-cycle strobe accompanying result_data
//   overflow_clr  synchronous clear of the sticky overflow flag
//   uart_txd      serial output, idles high
//   tx_busy       high while a frame is on the line (start through stop)
//   fifo_count    number of queued results
//   overflow      sticky: a result was dropped because the FIFO was full
//
// Optional feature
//   RESULT_TX_PARITY_EN  when defined, an even-parity bit is inserted between
//                        the last data bit and the stop bit (11-bit frame).
// -----------------------------------------------------------------------------
module result_uart_tx #(
  parameter int BAUD_DIV   = 87,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             result_data,
  input  logic                          result_valid,
  input  logic                          overflow_clr,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef RESULT_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // Result word zero-extended to the transmitted byte.
  function automatic logic [7:0] form_byte(input logic [DATA_W-1:0] d);
    return 8'(d);
  endfunction

`ifdef RESULT_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic                 baud_end;

  logic [DATA_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 drop;

  logic [7:0]           shift;
`ifdef RESULT_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);

  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);

  // The pop only happens from IDLE and looks at the registered count, so a
  // word pushed this cycle cannot be popped in the same cycle.
  assign pop  = (state == S_IDLE) && en && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push = result_valid && (!full || pop);
  assign drop = result_valid && full && !pop;

  // ---- FIFO control: pointers, occupancy, overflow flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // ---- FIFO storage (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result_data;
  end

  // ---- Shift register load / advance (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (pop) begin
      shift   <= form_byte(mem[rd_ptr]);
`ifdef RESULT_TX_PARITY_EN
      par_bit <= even_parity(form_byte(mem[rd_ptr]));
`endif
    end else if ((state == S_DATA) && baud_end) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // ---- Frame FSM with registered line outputs ----
  // uart_txd and tx_busy are registered from the current state, so the line
  // follows the FSM by one cycle: a pop at edge N+1 drops the line at N+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_busy <= (state != S_IDLE);

      case (state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          if (pop) begin
            baud_cnt <= '0;
            state    <= S_START;
          end
        end

        S_START: begin
          uart_txd <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          uart_txd <= shift[0];
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

`ifdef RESULT_TX_PARITY_EN
        S_PARITY: begin
          uart_txd <= par_bit;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          uart_txd <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          uart_txd <= 1'b1;
          baud_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_result_uart_tx
//
// Randomized and directed stimulus for result_uart_tx (BAUD_DIV=4,
// FIFO_DEPTH=8, DATA_W=5) checked every cycle against a queue-based model:
// a result queue, a timeline of expected line levels, and a frame-occupancy
// countdown. Honors RESULT_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_result_uart_tx;

  localparam int B     = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 5;
`ifdef RESULT_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic [DW-1:0] result_data;
  logic          result_valid;
  logic          overflow_clr;
  logic          uart_txd;
  logic          tx_busy;
  logic [3:0]    fifo_count;
  logic          overflow;

  result_uart_tx #(
    .BAUD_DIV  (B),
    .FIFO_DEPTH(DEPTH),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .result_data  (result_data),
    .result_valid (result_valid),
    .overflow_clr (overflow_clr),
    .uart_txd     (uart_txd),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];     // queued result bytes
  bit         line[$];   // expected uart_txd for upcoming edges
  int         busy_left; // cycles until the transmitter can start again
  bit         m_ovf;
  bit         exp_txd;
  bit         exp_busy;

  task automatic model_reset();
    mq.delete();
    line.delete();
    busy_left = 0;
    m_ovf     = 1'b0;
    exp_txd   = 1'b1;
    exp_busy  = 1'b0;
  endtask

  task automatic add_frame(input logic [7:0] b);
    bit par;
    par = ^b;
    repeat (B) line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (B) line.push_back(b[i]);
`ifdef RESULT_TX_PARITY_EN
    repeat (B) line.push_back(par);
`else
    if (par) begin end
`endif
    repeat (B) line.push_back(1'b1);
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit e, input bit c);
    bit pop;
    bit full;
    bit push;
    exp_txd  = 1'b1;
    exp_busy = 1'b0;
    if (line.size() > 0) begin
      exp_txd  = line.pop_front();
      exp_busy = 1'b1;
    end
    pop = 1'b0;
    if (busy_left > 0) busy_left--;
    else if (e && mq.size() > 0) pop = 1'b1;
    full = (mq.size() == DEPTH);
    push = v && (!full || pop);
    if (v && full && !pop) m_ovf = 1'b1;
    else if (c)            m_ovf = 1'b0;
    if (pop) begin
      add_frame(mq.pop_front());
      busy_left = FRAME_BITS * B;
    end
    if (push) mq.push_back(8'(d));
  endtask

  // One clock: drive at negedge, step model at posedge, compare 1 ns later.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit e, input bit c);
    @(negedge clk);
    result_valid = v;
    result_data  = d;
    en           = e;
    overflow_clr = c;
    @(posedge clk);
    model_edge(v, d, e, c);
    #1;
    chk("uart_txd",   32'(uart_txd),   32'(exp_txd));
    chk("tx_busy",    32'(tx_busy),    32'(exp_busy));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
  endtask

  task automatic idle(input int n, input bit e);
    repeat (n) cycle(1'b0, '0, e, 1'b0);
  endtask

  logic [DW-1:0] rd;

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    result_data  = '0;
    result_valid = 1'b0;
    overflow_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_txd",   32'(uart_txd),   32'd1);
    chk("rst_busy",  32'(tx_busy),    32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    rst = 1'b0;

    // Single frame with 5'h13.
    cycle(1'b1, 5'h13, 1'b1, 1'b0);
    idle(50, 1'b1);

    // Back-to-back results.
    cycle(1'b1, 5'h01, 1'b1, 1'b0);
    cycle(1'b1, 5'h1F, 1'b1, 1'b0);
    idle(2 * FRAME_BITS * B + 10, 1'b1);

    // Overflow with transmitter disabled, then drain and clear.
    repeat (9) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag",  32'(overflow),   32'd1);
    idle(8 * (FRAME_BITS * B + 1) + 5, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO, push on the same cycle as the IDLE pop.
    repeat (8) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("fullpop_count", 32'(fifo_count), 32'd8);
    chk("fullpop_ovf",   32'(overflow),   32'd0);
    idle(9 * (FRAME_BITS * B + 1) + 5, 1'b1);

    // Reset during data bit 3 with words still queued.
    cycle(1'b1, 5'h0A, 1'b1, 1'b0);
    cycle(1'b1, 5'h15, 1'b1, 1'b0);
    cycle(1'b1, 5'h03, 1'b1, 1'b0);
    idle(17, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_txd",   32'(uart_txd),   32'd1);
    chk("midrst_busy",  32'(tx_busy),    32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(30, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rd = DW'($urandom);
      cycle(($urandom % 5) == 0, rd, ($urandom % 8) != 0, ($urandom % 50) == 0);
    end
    idle(9 * (FRAME_BITS * B + 1) + 5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Output stage that consumes the 5-bit classification result and its one-cycle valid pulse from the FC stage.
- Buffers results in a small FIFO and serialises each one as a UART frame on a single pin for the host or logic analyser.
- Runs in the PE clock domain; all results are sourced and transmitted there.

Parameters:
- BAUD_DIV, 87, PE clock cycles per UART bit (10 MHz / 115200 ≈ 87); legal range 2..65535.
- FIFO_DEPTH, 8, result FIFO entries; must be a power of 2, minimum 2.
- DATA_W, 5, width of the result word; DATA_W ≤ 8.

Ports:
- clk  in  1  PE clock; all logic is rising-edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  transmit enable; gates frame start only.
- result_data  in  DATA_W  classification result.
- result_valid  in  1  one-cycle strobe; result_data is sampled when it is high.
- overflow_clr  in  1  synchronous clear of the overflow flag.
- uart_txd  out  1  serial output; idles high.
- tx_busy  out  1  high while a frame is on the line (START through STOP).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- overflow  out  1  sticky flag: a result was dropped.

Behaviour:
- Reset values: uart_txd=1, tx_busy=0, fifo_count=0, overflow=0; FSM=IDLE; FIFO pointers and baud/bit counters = 0.
- Reset asserted mid-frame: uart_txd returns high asynchronously and the frame is abandoned.
- Byte formation: tx_byte = {(8-DATA_W) zeros, result_data}. Bits are sent LSB first, 8 data bits, 1 stop bit.
- FIFO push: occurs on result_valid=1 when not full, or when full with a simultaneous pop.
- FIFO overflow: result_valid=1 while full with no pop drops the word and sets overflow=1.
- Overflow clearing: overflow_clr=1 clears the flag. If a drop and overflow_clr=1 occur in the same cycle, the set wins.
- Simultaneous push and pop on an empty FIFO: not possible, because a pop requires the FIFO to be non-empty on the previous cycle's count.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: if en=1 and fifo_count≠0, pop the head into the shift register, reset the baud counter, and go to START. Otherwise stay in IDLE.
- IDLE is always occupied for at least 1 cycle between frames, so back-to-back frames have a 1-cycle extra high gap.
- START: uart_txd=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- DATA: uart_txd=shift[0]. Every BAUD_DIV cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
- STOP: uart_txd=1 for BAUD_DIV cycles, then go to IDLE.
- tx_busy=1 in every state except IDLE.
- Latency: on an idle line with an empty FIFO and en=1, valid at cycle N → push at edge N → pop in IDLE at edge N+1 → uart_txd falls at edge N+2.
- Frame length is 10·BAUD_DIV cycles.
- en deasserted mid-frame: the current frame completes and no new frame starts. Pushes continue while en=0.
- The baud counter counts 0..BAUD_DIV-1 and wraps. The FIFO pointers wrap modulo FIFO_DEPTH; fifo_count distinguishes full from empty.

Optional Feature:
- Macro: RESULT_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and drives even parity (XOR of the 8 data bits) for BAUD_DIV cycles before STOP. Frame length becomes 11·BAUD_DIV cycles.
- Undefined: the PARITY state and its logic are absent; frame length is 10·BAUD_DIV cycles.

Test Plan:
- Single frame, BAUD_DIV=4, en=1, one valid with data=5'h13 → txd low at edge N+2 for 4 cycles, then bits 1,1,0,0,1,0,0,0 at 4 cycles each, then high. tx_busy high for 40 cycles.
- Back-to-back: pulses with 5'h01 then 5'h1F on consecutive cycles → fifo_count peaks at 1. Two frames separated by 4 stop cycles plus a 1-cycle idle gap; second byte is 8'h1F.
- Overflow: en=0, FIFO_DEPTH=8, 9 valids → fifo_count=8, overflow=1, ninth word lost. Then en=1: 8 frames are sent; overflow_clr pulse → overflow=0.
- Full plus pop same cycle: FIFO full, frame ending, valid arrives on the cycle of the IDLE pop → word accepted, overflow stays 0, fifo_count stays 8.
- Reset mid-DATA: assert rst during bit 3 → uart_txd=1 and tx_busy=0 immediately. After release, fifo_count=0 and the line stays idle.
- Parity build with RESULT_TX_PARITY_EN, data=5'h07 → parity bit = 1 (three ones), frame length 44 cycles at BAUD_DIV=4.
